// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the program counter and the
// instruction decoder. Issues reads to a 1-cycle-latency synchronous
// instruction memory, buffers returned words in a 2-entry FIFO and presents
// them over a valid/ready handshake. Fetch stops after a halt word is
// buffered. A redirect flushes the stage and restarts fetch at a new PC.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req, imem_addr      read request / address (address equals pc)
//   imem_rdata               read data, valid the cycle after the request
//   inst_valid, inst_ready   decoder handshake for the FIFO head
//   inst_data, inst_pc       head instruction word and its address (0 when invalid)
//   redirect_valid/_pc       flush and restart fetch at redirect_pc
//   halted                   fetch stopped by a halt word
module fetch_unit #(
   parameter int ADDR_WIDTH = 5,
   parameter int WIDTH = 32,
   parameter logic [6:0] HALT_OPCODE = 7'b0000001
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0]      imem_rdata,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [WIDTH-1:0]      inst_data,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  halted
);

   localparam int DEPTH = 2;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [1:0]            count_q, count_d;
   logic                  inflight_q, inflight_d;
   logic                  kill_q, kill_d;
   logic                  halted_q, halted_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;

   logic [WIDTH-1:0]      data_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DEPTH-1:0]      wr_en;

   logic                  deq;
   logic                  enq;
   logic                  enq_halt;
   logic [2:0]            credit;

   // Handshake, request and datapath outputs
   always_comb begin
      // A redirect cycle never transfers: the head is about to be flushed.
      inst_valid = (count_q != 2'd0) && !redirect_valid;
      deq        = inst_valid && inst_ready;
      // Slots that will be occupied once the outstanding response lands,
      // net of the word leaving this cycle; keeps the FIFO from overflowing.
      credit     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
      // Gated by rst so the request drops as soon as reset asserts.
      imem_req   = !rst && !halted_q && !redirect_valid && (credit < 3'd2);
      imem_addr  = pc_q;
      inst_data  = inst_valid ? data_q[rd_ptr_q] : '0;
      inst_pc    = inst_valid ? addr_q[rd_ptr_q] : '0;
      halted     = halted_q;
      enq        = inflight_q && !kill_q && !redirect_valid;
      enq_halt   = enq && (imem_rdata[6:0] == HALT_OPCODE);
   end

   // Next-state logic; redirect overrides everything else
   always_comb begin
      pc_d       = imem_req ? pc_q + 1'b1 : pc_q;   // wraps modulo 2^ADDR_WIDTH
      req_addr_d = imem_req ? pc_q : req_addr_q;
      inflight_d = imem_req;
      count_d    = count_q + {1'b0, enq} - {1'b0, deq};
      wr_ptr_d   = wr_ptr_q ^ enq;
      rd_ptr_d   = rd_ptr_q ^ deq;
      halted_d   = halted_q | enq_halt;
      // The request issued alongside a halt word is fetched past the halt.
      kill_d     = enq_halt && imem_req;
      if (redirect_valid) begin
         pc_d     = redirect_pc;
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         halted_d = 1'b0;
         kill_d   = inflight_q;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = enq && (wr_ptr_q == 1'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= '0;
         req_addr_q <= '0;
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
         halted_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
         halted_q   <= halted_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
               data_q[i] <= imem_rdata;
               addr_q[i] <= req_addr_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [4:0]  imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [4:0]  inst_pc;
   logic        redirect_valid;
   logic [4:0]  redirect_pc;
   logic        halted;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.ADDR_WIDTH(5), .WIDTH(32), .HALT_OPCODE(7'b0000001)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(halted)
   );

   always #5 clk = ~clk;

   // mem[a] = {25'h1A5, a} (zero-extended), mem[12] = halt word
   function automatic logic [31:0] mem_word(input logic [4:0] a);
      logic [29:0] w;
      w = {25'h1A5, a};
      return (a == 5'd12) ? 32'h0000_0001 : {2'b00, w};
   endfunction

   // Synchronous instruction memory, one-cycle read latency
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem_word(imem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      @(negedge clk); #1;
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_data", inst_data, 32'd0);
      chk("rst_pc", 32'(inst_pc), 32'd0);

      // Reset stream: request every cycle, first valid two cycles later
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) begin rst = 1'b0; inst_ready = 1'b1; end
         #1;
         $display("cycle %0d stream req=%0b addr=%0d valid=%0b pc=%0d", k, imem_req, imem_addr, inst_valid, inst_pc);
         chk("str_req", 32'(imem_req), 32'd1);
         chk("str_addr", 32'(imem_addr), 32'(k));
         chk("str_valid", 32'(inst_valid), 32'(k >= 2));
         if (k >= 2) begin
            chk("str_pc", 32'(inst_pc), 32'(k - 2));
            chk("str_data", inst_data, mem_word(5'(k - 2)));
         end
      end

      // Backpressure: head pc 3 held for 5 cycles, requests stop
      for (int k = 5; k < 10; k++) begin
         @(negedge clk); inst_ready = 1'b0; #1;
         $display("cycle %0d stall valid=%0b pc=%0d req=%0b", k, inst_valid, inst_pc, imem_req);
         chk("bp_valid", 32'(inst_valid), 32'd1);
         chk("bp_pc", 32'(inst_pc), 32'd3);
         chk("bp_data", inst_data, mem_word(5'd3));
         chk("bp_req", 32'(imem_req), 32'd0);
      end

      // Resume: pcs 3..11 with no gaps, requests up to address 13
      for (int k = 10; k < 19; k++) begin
         @(negedge clk); inst_ready = 1'b1; #1;
         $display("cycle %0d resume pc=%0d req=%0b addr=%0d", k, inst_pc, imem_req, imem_addr);
         chk("rs_valid", 32'(inst_valid), 32'd1);
         chk("rs_pc", 32'(inst_pc), 32'(k - 7));
         chk("rs_data", inst_data, mem_word(5'(k - 7)));
         chk("rs_req", 32'(imem_req), 32'd1);
         chk("rs_addr", 32'(imem_addr), 32'(k - 5));
         chk("rs_halted", 32'(halted), 32'd0);
      end

      // Halt word delivered, halted set
      @(negedge clk); #1;
      $display("cycle 19 halt valid=%0b pc=%0d data=%h halted=%0b", inst_valid, inst_pc, inst_data, halted);
      chk("h_valid", 32'(inst_valid), 32'd1);
      chk("h_pc", 32'(inst_pc), 32'd12);
      chk("h_data", inst_data, 32'h0000_0001);
      chk("h_halted", 32'(halted), 32'd1);
      chk("h_req", 32'(imem_req), 32'd0);

      // Halted for 20 cycles: address 13 never delivered, no requests
      for (int k = 20; k < 40; k++) begin
         @(negedge clk); #1;
         $display("cycle %0d halted valid=%0b req=%0b halted=%0b", k, inst_valid, imem_req, halted);
         chk("hd_valid", 32'(inst_valid), 32'd0);
         chk("hd_data", inst_data, 32'd0);
         chk("hd_req", 32'(imem_req), 32'd0);
         chk("hd_halted", 32'(halted), 32'd1);
      end

      // Redirect while halted to 20
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 5'd20; #1;
      $display("cycle 40 redirect->20 valid=%0b req=%0b", inst_valid, imem_req);
      chk("r1_valid", 32'(inst_valid), 32'd0);
      chk("r1_req", 32'(imem_req), 32'd0);
      @(negedge clk); redirect_valid = 1'b0; #1;
      $display("cycle 41 req=%0b addr=%0d halted=%0b", imem_req, imem_addr, halted);
      chk("r1_halted", 32'(halted), 32'd0);
      chk("r1_req2", 32'(imem_req), 32'd1);
      chk("r1_addr", 32'(imem_addr), 32'd20);
      @(negedge clk); #1;
      $display("cycle 42 req=%0b addr=%0d valid=%0b", imem_req, imem_addr, inst_valid);
      chk("r1_addr2", 32'(imem_addr), 32'd21);
      chk("r1_valid2", 32'(inst_valid), 32'd0);
      for (int k = 43; k < 46; k++) begin
         @(negedge clk); #1;
         $display("cycle %0d pc=%0d addr=%0d", k, inst_pc, imem_addr);
         chk("r1_pc", 32'(inst_pc), 32'(k - 23));
         chk("r1_sv", 32'(inst_valid), 32'd1);
         chk("r1_saddr", 32'(imem_addr), 32'(k - 21));
      end

      // Fill FIFO under backpressure, then redirect to 5
      for (int k = 46; k < 48; k++) begin
         @(negedge clk); inst_ready = 1'b0; #1;
         $display("cycle %0d fill pc=%0d req=%0b", k, inst_pc, imem_req);
         chk("f_valid", 32'(inst_valid), 32'd1);
         chk("f_pc", 32'(inst_pc), 32'd23);
         chk("f_req", 32'(imem_req), 32'd0);
      end
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 5'd5; #1;
      $display("cycle 48 redirect->5 valid=%0b req=%0b", inst_valid, imem_req);
      chk("r2_valid", 32'(inst_valid), 32'd0);
      chk("r2_req", 32'(imem_req), 32'd0);
      @(negedge clk); redirect_valid = 1'b0; inst_ready = 1'b1; #1;
      $display("cycle 49 req=%0b addr=%0d valid=%0b", imem_req, imem_addr, inst_valid);
      chk("r2_addr", 32'(imem_addr), 32'd5);
      chk("r2_valid2", 32'(inst_valid), 32'd0);
      @(negedge clk); #1;
      chk("r2_valid3", 32'(inst_valid), 32'd0);
      chk("r2_addr2", 32'(imem_addr), 32'd6);
      @(negedge clk); #1;
      $display("cycle 51 valid=%0b pc=%0d", inst_valid, inst_pc);
      chk("r2_valid4", 32'(inst_valid), 32'd1);
      chk("r2_pc", 32'(inst_pc), 32'd5);
      chk("r2_data", inst_data, mem_word(5'd5));

      // Redirect with a response in flight, to 30, then wrap
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 5'd30; #1;
      $display("cycle 52 redirect->30 valid=%0b req=%0b", inst_valid, imem_req);
      chk("r3_valid", 32'(inst_valid), 32'd0);
      chk("r3_req", 32'(imem_req), 32'd0);
      @(negedge clk); redirect_valid = 1'b0; #1;
      chk("r3_addr", 32'(imem_addr), 32'd30);
      chk("r3_v1", 32'(inst_valid), 32'd0);
      @(negedge clk); #1;
      chk("r3_addr2", 32'(imem_addr), 32'd31);
      chk("r3_v2", 32'(inst_valid), 32'd0);
      for (int k = 55; k < 59; k++) begin
         logic [4:0] e;
         e = 5'(30 + k - 55);
         @(negedge clk); #1;
         $display("cycle %0d wrap pc=%0d addr=%0d", k, inst_pc, imem_addr);
         chk("w_valid", 32'(inst_valid), 32'd1);
         chk("w_pc", 32'(inst_pc), 32'(e));
         chk("w_data", inst_data, mem_word(e));
         chk("w_addr", 32'(imem_addr), 32'(5'(k - 55)));
      end

      // Asynchronous reset between edges
      #2 rst = 1'b1; #1;
      $display("async reset valid=%0b req=%0b halted=%0b", inst_valid, imem_req, halted);
      chk("ar_valid", 32'(inst_valid), 32'd0);
      chk("ar_req", 32'(imem_req), 32'd0);
      chk("ar_halted", 32'(halted), 32'd0);
      chk("ar_data", inst_data, 32'd0);
      chk("ar_pc", 32'(inst_pc), 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      $display("post reset req=%0b addr=%0d", imem_req, imem_addr);
      chk("pr_req", 32'(imem_req), 32'd1);
      chk("pr_addr", 32'(imem_addr), 32'd0);
      chk("pr_valid", 32'(inst_valid), 32'd0);
      @(negedge clk); #1;
      chk("pr_addr2", 32'(imem_addr), 32'd1);
      @(negedge clk); #1;
      $display("post reset valid=%0b pc=%0d", inst_valid, inst_pc);
      chk("pr_valid2", 32'(inst_valid), 32'd1);
      chk("pr_pc", 32'(inst_pc), 32'd0);
      chk("pr_data", inst_data, mem_word(5'd0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
